// File: rtl/prio_enc_rr_pkg.sv
// Shared types and helpers for the registered round-robin priority encoder.
package prio_enc_rr_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational highest-index-wins priority encoder.
module prio_enc_core
    import prio_enc_rr_pkg::*;
#(
    parameter int unsigned N = 10,
    localparam int unsigned W = clog2(N)
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    always_comb begin
        idx_o = '0;
        for (int k = 0; k < N; k++) begin
            if (req_i[k]) begin
                idx_o = W'(k);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/prio_enc_rr.sv
// Registered N-line priority encoder with fixed or round-robin arbitration and
// a valid/ready output that holds each grant until it is accepted.
module prio_enc_rr
    import prio_enc_rr_pkg::*;
#(
    parameter int unsigned N = 10,
    localparam int unsigned W = clog2(N),
    parameter logic [W-1:0] IDLE_CODE = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i,
    input  logic         i_mode,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o,
    output logic [N-1:0] o_onehot,
    output logic         o_multi
);

    state_e       state_q;
    logic         valid_q;
    logic [W-1:0] code_q;
    logic [N-1:0] onehot_q;
    logic         multi_q;
    logic [W-1:0] rr_ptr_q;

    logic [N-1:0] rr_mask;
    logic [N-1:0] masked_req;
    logic [W-1:0] u_idx;
    logic [W-1:0] m_idx;
    logic         u_any;
    logic         m_any;
    logic [W-1:0] grant_d;
    logic [N-1:0] onehot_d;
    logic         multi_d;
    logic         load;

    // Only indices strictly below the last winner get first pick in RR mode.
    always_comb begin
        rr_mask = '0;
        for (int k = 0; k < N; k++) begin
            rr_mask[k] = (W'(k) < rr_ptr_q);
        end
    end

    assign masked_req = i & rr_mask;

    prio_enc_core #(
        .N (N)
    ) u_enc_full (
        .req_i (i),
        .idx_o (u_idx),
        .any_o (u_any)
    );

    prio_enc_core #(
        .N (N)
    ) u_enc_masked (
        .req_i (masked_req),
        .idx_o (m_idx),
        .any_o (m_any)
    );

    assign grant_d  = (i_mode && m_any) ? m_idx : u_idx;
    assign onehot_d = N'(1) << grant_d;
    assign multi_d  = |(i & (i - N'(1)));
    assign load     = u_any && ((state_q == StIdle) || i_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            valid_q  <= 1'b0;
            code_q   <= IDLE_CODE;
            onehot_q <= '0;
            multi_q  <= 1'b0;
            rr_ptr_q <= '0;
        end else if (load) begin
            state_q  <= StHold;
            valid_q  <= 1'b1;
            code_q   <= grant_d;
            onehot_q <= onehot_d;
            multi_q  <= multi_d;
            if (i_mode) begin
                rr_ptr_q <= grant_d;
            end
        end else if ((state_q == StHold) && i_ready) begin
            state_q  <= StIdle;
            valid_q  <= 1'b0;
            code_q   <= IDLE_CODE;
            onehot_q <= '0;
            multi_q  <= 1'b0;
        end
    end

    assign o_valid  = valid_q;
    assign o        = code_q;
    assign o_onehot = onehot_q;
    assign o_multi  = multi_q;

endmodule

// File: tb/tb_prio_enc_rr.sv
// Directed scoreboard bench for prio_enc_rr with N=10.
module tb_prio_enc_rr;

    typedef struct packed {
        logic       v;
        logic [3:0] c;
        logic [9:0] oh;
        logic       m;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [9:0] i;
    logic       i_mode;
    logic       i_ready;
    logic       o_valid;
    logic [3:0] o;
    logic [9:0] o_onehot;
    logic       o_multi;

    int   checks;
    int   failures;
    exp_t sb[$];

    prio_enc_rr #(
        .N (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i        (i),
        .i_mode   (i_mode),
        .i_ready  (i_ready),
        .o_valid  (o_valid),
        .o        (o),
        .o_onehot (o_onehot),
        .o_multi  (o_multi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t mk(input logic v, input logic [3:0] c, input logic [9:0] oh,
                                input logic m);
        exp_t e;
        e.v  = v;
        e.c  = c;
        e.oh = oh;
        e.m  = m;
        return e;
    endfunction

    task automatic check_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard: got empty queue, required one entry", tag);
        end else begin
            e = sb.pop_front();
            checks++;
            assert (o_valid === e.v) else begin
                failures++;
                $error("FAIL %s o_valid: got %b required %b", tag, o_valid, e.v);
            end
            checks++;
            assert (o === e.c) else begin
                failures++;
                $error("FAIL %s o: got %h required %h", tag, o, e.c);
            end
            checks++;
            assert (o_onehot === e.oh) else begin
                failures++;
                $error("FAIL %s o_onehot: got %b required %b", tag, o_onehot, e.oh);
            end
            checks++;
            assert (o_multi === e.m) else begin
                failures++;
                $error("FAIL %s o_multi: got %b required %b", tag, o_multi, e.m);
            end
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, compare at the next falling edge.
    task automatic step(input logic [9:0] iv, input logic md, input logic rd, input exp_t e,
                        input string tag);
        i       = iv;
        i_mode  = md;
        i_ready = rd;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check_pop(tag);
    endtask

    exp_t idle_e;

    initial begin
        checks   = 0;
        failures = 0;
        idle_e   = mk(1'b0, 4'hF, 10'b0, 1'b0);
        rst      = 1'b1;
        i        = '0;
        i_mode   = 1'b0;
        i_ready  = 1'b0;

        @(negedge clk);
        sb.push_back(idle_e);
        check_pop("reset");
        rst = 1'b0;

        for (int k = 0; k < 3; k++) begin
            step(10'b0, 1'b0, 1'b1, idle_e, "idle_no_req");
        end

        for (int k = 0; k < 10; k++) begin
            step(10'b1 << k, 1'b0, 1'b1, mk(1'b1, 4'(k), 10'b1 << k, 1'b0), "fixed_walk");
        end

        step(10'b1100000000, 1'b0, 1'b1, mk(1'b1, 4'd9, 10'b1000000000, 1'b1), "fixed_top2");
        step(10'b0111111111, 1'b0, 1'b1, mk(1'b1, 4'd8, 10'b0100000000, 1'b1), "fixed_low9");
        step(10'b0, 1'b0, 1'b1, idle_e, "drop_to_idle");

        step(10'b0000010000, 1'b0, 1'b0, mk(1'b1, 4'd4, 10'b0000010000, 1'b0), "bp_load");
        step(10'b1000000000, 1'b0, 1'b0, mk(1'b1, 4'd4, 10'b0000010000, 1'b0), "bp_hold1");
        step(10'b0000000000, 1'b0, 1'b0, mk(1'b1, 4'd4, 10'b0000010000, 1'b0), "bp_hold_drop");
        step(10'b1000000000, 1'b1, 1'b0, mk(1'b1, 4'd4, 10'b0000010000, 1'b0), "bp_hold_mode");
        step(10'b1000000000, 1'b0, 1'b1, mk(1'b1, 4'd9, 10'b1000000000, 1'b0), "bp_handshake");
        step(10'b0, 1'b0, 1'b1, idle_e, "bp_idle");

        // Fixed mode must not have moved the RR pointer, so the first RR grant is 9.
        step(10'b1000010001, 1'b1, 1'b1, mk(1'b1, 4'd9, 10'b1000000000, 1'b1), "rr_a9");
        step(10'b1000010001, 1'b1, 1'b1, mk(1'b1, 4'd4, 10'b0000010000, 1'b1), "rr_b4");
        step(10'b1000010001, 1'b1, 1'b1, mk(1'b1, 4'd0, 10'b0000000001, 1'b1), "rr_c0");
        step(10'b1000010001, 1'b1, 1'b1, mk(1'b1, 4'd9, 10'b1000000000, 1'b1), "rr_d9");
        step(10'b1000010001, 1'b1, 1'b1, mk(1'b1, 4'd4, 10'b0000010000, 1'b1), "rr_e4");

        step(10'b0010000000, 1'b1, 1'b1, mk(1'b1, 4'd7, 10'b0010000000, 1'b0), "rr_load7");
        step(10'b0010000000, 1'b1, 1'b0, mk(1'b1, 4'd7, 10'b0010000000, 1'b0), "rr_hold7");

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b1;
        i   = '0;
        #1;
        sb.push_back(idle_e);
        check_pop("async_rst");
        #1;
        rst = 1'b0;
        @(negedge clk);
        sb.push_back(idle_e);
        check_pop("post_rst_idle");

        step(10'b1000010001, 1'b1, 1'b1, mk(1'b1, 4'd9, 10'b1000000000, 1'b1), "rr_restart9");
        step(10'b1000010001, 1'b1, 1'b1, mk(1'b1, 4'd4, 10'b0000010000, 1'b1), "rr_restart4");
        step(10'b0, 1'b1, 1'b1, idle_e, "final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
